// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Purpose  : Shared definitions for the universal shift register: the 3-bit
//             operation-select encoding and a helper that classifies which
//             operations advance the transfer counter.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package shift_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

    // Shifts and rotates are the operations that count as a bit transfer.
    function automatic logic is_shift_op(input logic [2:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) ||
               (mode == MODE_ROL) || (mode == MODE_ROR);
    endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_cell.sv
`default_nettype none
// ============================================================================
//  Module   : shift_cell
//  Purpose  : One bit of the universal shift register: a 5:1 next-state mux
//             (hold / from lower neighbour / from upper neighbour / load /
//             clear) feeding a flop with synchronous reset and enable.
//  Ports    : clk      rising-edge clock
//             rst      synchronous active-high reset, loads rst_val
//             en       enable; 0 holds the bit
//             rst_val  value taken on reset
//             mode     operation select (shift_pkg encoding)
//             from_lo  bit arriving on a left shift/rotate
//             from_hi  bit arriving on a right shift/rotate
//             ld       parallel load bit
//             q        stored bit
//  Revision : 1.0  initial release
// ============================================================================
module shift_cell
    import shift_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rst_val,
    input  logic [2:0] mode,
    input  logic       from_lo,
    input  logic       from_hi,
    input  logic       ld,
    output logic       q
);

    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        case (mode)
            MODE_SHL, MODE_ROL: w_next = from_lo;
            MODE_SHR, MODE_ROR: w_next = from_hi;
            MODE_LOAD:          w_next = ld;
            MODE_CLEAR:         w_next = 1'b0;
            default:            w_next = r_q;   // HOLD and reserved
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= rst_val;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule : shift_cell
`default_nettype wire

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_univ
//  Purpose  : Parametrised universal shift register with hold, shift left/
//             right, rotate left/right, parallel load and clear, per-cycle
//             enable, serial in/out and a transfer counter that pulses done
//             after WIDTH shift operations.
//  Ports    : clk     rising-edge clock
//             rst     synchronous active-high reset (priority over en/mode)
//             en      operation enable; 0 freezes q and cnt
//             mode    operation select (shift_pkg encoding)
//             sin     serial input for SHL/SHR
//             d       parallel load data
//             q       register contents
//             sout_l  q[WIDTH-1]
//             sout_r  q[0]
//             cnt     shift ops since last load/clear/reset/wrap
//             done    one-cycle pulse after the WIDTH-th shift op
//  Revision : 1.0  initial release
// ============================================================================
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    localparam int                CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_from_lo;
    logic [WIDTH-1:0] w_from_hi;
    logic             w_lsb_in;
    logic             w_msb_in;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    // End-of-register feed: rotates wrap the opposite end, shifts take sin.
    assign w_lsb_in  = (mode == MODE_ROL) ? w_q[WIDTH-1] : sin;
    assign w_msb_in  = (mode == MODE_ROR) ? w_q[0]       : sin;
    assign w_from_lo = {w_q[WIDTH-2:0], w_lsb_in};
    assign w_from_hi = {w_msb_in, w_q[WIDTH-1:1]};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            shift_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .rst_val (RESET_VALUE[i]),
                .mode    (mode),
                .from_lo (w_from_lo[i]),
                .from_hi (w_from_hi[i]),
                .ld      (d[i]),
                .q       (w_q[i])
            );
        end
    endgenerate

    // Transfer counter: wraps after WIDTH shift ops regardless of direction,
    // and the wrap edge raises done for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en) begin
            r_done <= 1'b0;
        end else if (is_shift_op(mode)) begin
            if (r_cnt == c_CNT_LAST) begin
                r_cnt  <= '0;
                r_done <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_done <= 1'b0;
            end
        end else if ((mode == MODE_LOAD) || (mode == MODE_CLEAR)) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign q      = w_q;
    assign sout_l = w_q[WIDTH-1];
    assign sout_r = w_q[0];
    assign cnt    = r_cnt;
    assign done   = r_done;

endmodule : shift_reg_univ
`default_nettype wire
